saida_dados_display: RTL

- Output-side counterpart of the switch data-entry path: on an output request from the control unit, captures a 32-bit two's-complement word and converts it to signed decimal.
- Conversion is sequential binary-to-BCD (double-dabble, one bit per cycle).
- Result drives eight active-low seven-segment displays. Display contents are held until the next request.
- Uses a level request/acknowledge handshake with the control unit.

---
 rtl/saida_dados_display_if.sv | 22 ++
 rtl/saida_dados_display.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/saida_dados_display_if.sv
// rtl/saida_dados_display_if.sv - request/ack handshake, data word and segment outputs
// master = control unit side, slave = display output block
interface saida_dados_display_if;
  logic [31:0] dado;
  logic        estagioSaidaUC;
  logic        estagioSaidaDisplay;
  logic        ocupado;
  logic        overflow;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;

  modport master (
    output dado, estagioSaidaUC,
    input  estagioSaidaDisplay, ocupado, overflow,
    input  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7
  );

  modport slave (
    input  dado, estagioSaidaUC,
    output estagioSaidaDisplay, ocupado, overflow,
    output hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7
  );
endinterface

// File: rtl/saida_dados_display.sv
// rtl/saida_dados_display.sv - signed 32-bit word to eight seven-segment displays
// Sequential double-dabble conversion, one bit per clock, level request/ack handshake.
module saida_dados_display #(
  parameter int          SEG_ATIVO_BAIXO = 1,
  parameter int unsigned MAX_MAGNITUDE   = 9999999
) (
  input  logic                 clock,
  input  logic                 reset,
  saida_dados_display_if.slave bus
);

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b0111111;

  function automatic logic [27:0] paraBcd(input int unsigned v);
    logic [27:0] r;
    int unsigned x;
    x = v;
    r = '0;
    for (int i = 0; i < 7; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Valid BCD compares correctly as a plain unsigned number.
  localparam logic [27:0] MAX_BCD =
    paraBcd((MAX_MAGNITUDE > 32'd9999999) ? 32'd9999999 : MAX_MAGNITUDE);

  function automatic logic [6:0] codifica(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  function automatic logic [6:0] pol(input logic [6:0] s);
    return (SEG_ATIVO_BAIXO != 0) ? s : ~s;
  endfunction

  typedef enum logic [1:0] {OCIOSO, CONVERTE, ATUALIZA, ESPERA} estado_t;

  estado_t     estado;
  logic        sinal;
  logic [31:0] magnitude;
  logic [39:0] bcd;
  logic [5:0]  contador;
  logic        ack;
  logic        ocupadoReg;
  logic        overflowReg;
  logic [6:0]  hexReg [8];

  logic [39:0] bcdAjustado;
  logic [71:0] deslocado;
  logic        estouro;
  logic [6:0]  segsNovos [7];
  logic        visto;

  always_comb begin
    bcdAjustado = '0;
    for (int i = 0; i < 10; i++) begin
      bcdAjustado[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end
  end

  assign deslocado = {bcdAjustado, magnitude} << 1;
  assign estouro   = (bcd[39:28] != 12'd0) || (bcd[27:0] > MAX_BCD);

  // Leading-zero blanking: a digit shows once any higher digit was nonzero; digit 0 always shows.
  always_comb begin
    visto = 1'b0;
    for (int i = 0; i < 7; i++) segsNovos[i] = BLANK;
    for (int i = 6; i >= 0; i--) begin
      if (bcd[4*i +: 4] != 4'd0 || i == 0) visto = 1'b1;
      segsNovos[i] = estouro ? DASH : (visto ? codifica(bcd[4*i +: 4]) : BLANK);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado      <= OCIOSO;
      sinal       <= 1'b0;
      magnitude   <= '0;
      bcd         <= '0;
      contador    <= '0;
      ack         <= 1'b0;
      ocupadoReg  <= 1'b0;
      overflowReg <= 1'b0;
      for (int i = 0; i < 8; i++) hexReg[i] <= pol(BLANK);
    end else begin
      case (estado)
        OCIOSO: begin
          if (bus.estagioSaidaUC && !ack) begin
            sinal      <= bus.dado[31];
            magnitude  <= bus.dado[31] ? (~bus.dado + 32'd1) : bus.dado;
            bcd        <= '0;
            contador   <= '0;
            ocupadoReg <= 1'b1;
            estado     <= CONVERTE;
          end
        end
        CONVERTE: begin
          {bcd, magnitude} <= deslocado;
          contador         <= contador + 6'd1;
          if (contador == 6'd31) estado <= ATUALIZA;
        end
        ATUALIZA: begin
          for (int i = 0; i < 7; i++) hexReg[i] <= pol(segsNovos[i]);
          hexReg[7]   <= pol(sinal ? DASH : BLANK);
          overflowReg <= estouro;
          ocupadoReg  <= 1'b0;
          if (bus.estagioSaidaUC) begin
            ack    <= 1'b1;
            estado <= ESPERA;
          end else begin
            estado <= OCIOSO;
          end
        end
        default: begin
          if (!bus.estagioSaidaUC) begin
            ack    <= 1'b0;
            estado <= OCIOSO;
          end
        end
      endcase
    end
  end

  assign bus.estagioSaidaDisplay = ack;
  assign bus.ocupado             = ocupadoReg;
  assign bus.overflow            = overflowReg;
  assign bus.hex0 = hexReg[0];
  assign bus.hex1 = hexReg[1];
  assign bus.hex2 = hexReg[2];
  assign bus.hex3 = hexReg[3];
  assign bus.hex4 = hexReg[4];
  assign bus.hex5 = hexReg[5];
  assign bus.hex6 = hexReg[6];
  assign bus.hex7 = hexReg[7];

endmodule
